// File: rtl/turn_scheduler_pkg.sv
// rtl/turn_scheduler_pkg.sv - shared constants, state encoding and helpers for the turn scheduler
package turn_scheduler_pkg;

    localparam int GRID_CELLS = 36;
    localparam int MAX_MISSES = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TURN    = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    function automatic logic onehot36(input logic [GRID_CELLS-1:0] v);
        return (v != '0) && ((v & (v - {{(GRID_CELLS-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/player_board.sv
// rtl/player_board.sv - one player's shot grid, miss thermometer and fleet-sunk compare
module player_board
    import turn_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear_i,
    input  logic                  shoot_i,
    input  logic [GRID_CELLS-1:0] cell_i,
    input  logic                  miss_i,
    input  logic [GRID_CELLS-1:0] opp_ships_i,
    output logic [GRID_CELLS-1:0] shots_o,
    output logic [MAX_MISSES-1:0] lives_o,
    output logic [MAX_MISSES-1:0] lives_next_o,
    output logic                  sunk_o
);

    logic [GRID_CELLS-1:0] shots_q, shots_d;
    logic [MAX_MISSES-1:0] lives_q, lives_d;

    always_comb begin
        shots_d = shots_q;
        lives_d = lives_q;
        if (clear_i) begin
            shots_d = '0;
            lives_d = '1;
        end else begin
            if (shoot_i) shots_d = shots_q | cell_i;
            if (miss_i)  lives_d = lives_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shots_q <= '0;
            lives_q <= '1;
        end else begin
            shots_q <= shots_d;
            lives_q <= lives_d;
        end
    end

    // An empty fleet must never count as sunk.
    assign sunk_o       = (opp_ships_i != '0) && ((shots_q & opp_ships_i) == opp_ships_i);
    assign shots_o      = shots_q;
    assign lives_o      = lives_q;
    assign lives_next_o = lives_d;

endmodule

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - two-player battleship turn sequencer sharing one cursor/attack path
module turn_scheduler
    import turn_scheduler_pkg::*;
#(
    parameter int SWITCH_CYCLES = 2,
    parameter int TURN_TIMEOUT  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  attack,
    input  logic [GRID_CELLS-1:0] cursor,
    input  logic [GRID_CELLS-1:0] ships_p0,
    input  logic [GRID_CELLS-1:0] ships_p1,
    output logic                  active_player,
    output logic [GRID_CELLS-1:0] shots_p0,
    output logic [GRID_CELLS-1:0] shots_p1,
    output logic [MAX_MISSES-1:0] lives_p0,
    output logic [MAX_MISSES-1:0] lives_p1,
    output logic                  last_hit,
    output logic                  game_over,
    output logic                  winner,
    output logic [2:0]            state
);

    localparam int CNT_W = 8;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  active_q, active_d;
    logic                  last_hit_q, last_hit_d;
    logic                  game_over_q, game_over_d;
    logic                  winner_q, winner_d;
    logic                  armed_q, armed_d;
    logic                  attack_q;
    logic [GRID_CELLS-1:0] cursor_q;

    logic                  atk_pulse, valid_shot, hit, new_game, resolve_miss;
    logic [GRID_CELLS-1:0] own_shots, opp_ships;
    logic [MAX_MISSES-1:0] lives_next_p0, lives_next_p1, own_lives_next;
    logic                  sunk_p0, sunk_p1, own_sunk;

    assign atk_pulse      = attack & ~attack_q;
    assign own_shots      = active_q ? shots_p1 : shots_p0;
    assign opp_ships      = active_q ? ships_p0 : ships_p1;
    assign own_sunk       = active_q ? sunk_p1 : sunk_p0;
    assign own_lives_next = active_q ? lives_next_p1 : lives_next_p0;
    assign valid_shot     = (state_q == ST_TURN) && atk_pulse && onehot36(cursor)
                            && ((cursor & own_shots) == '0);
    assign hit            = |(cursor_q & opp_ships);
    assign new_game       = (state_q == ST_IDLE) && start;
    assign resolve_miss   = (state_q == ST_RESOLVE) && !hit;

    player_board u_board_p0 (
        .clk          (clk),
        .resetn       (reset),
        .clear_i      (new_game),
        .shoot_i      (valid_shot && !active_q),
        .cell_i       (cursor),
        .miss_i       (resolve_miss && !active_q),
        .opp_ships_i  (ships_p1),
        .shots_o      (shots_p0),
        .lives_o      (lives_p0),
        .lives_next_o (lives_next_p0),
        .sunk_o       (sunk_p0)
    );

    player_board u_board_p1 (
        .clk          (clk),
        .resetn       (reset),
        .clear_i      (new_game),
        .shoot_i      (valid_shot && active_q),
        .cell_i       (cursor),
        .miss_i       (resolve_miss && active_q),
        .opp_ships_i  (ships_p0),
        .shots_o      (shots_p1),
        .lives_o      (lives_p1),
        .lives_next_o (lives_next_p1),
        .sunk_o       (sunk_p1)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        last_hit_d  = last_hit_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        armed_d     = armed_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_TURN;
                    cnt_d       = '0;
                    active_d    = 1'b0;
                    last_hit_d  = 1'b0;
                    game_over_d = 1'b0;
                    winner_d    = 1'b0;
                end
            end
            ST_TURN: begin
                cnt_d = cnt_q + 1'b1;
                if (valid_shot) begin
                    state_d = ST_RESOLVE;
                end else if (cnt_q == CNT_W'(TURN_TIMEOUT - 1)) begin
                    state_d = ST_SWITCH;
                    cnt_d   = '0;
                end
            end
            ST_RESOLVE: begin
                last_hit_d = hit;
                cnt_d      = '0;
                if (own_sunk) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                    winner_d    = active_q;
                    armed_d     = 1'b0;
                end else if (own_lives_next == '0) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                    winner_d    = ~active_q;
                    armed_d     = 1'b0;
                end else if (hit) begin
                    state_d = ST_TURN;
                end else begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (cnt_q == CNT_W'(SWITCH_CYCLES - 1)) begin
                    state_d  = ST_TURN;
                    active_d = ~active_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OVER: begin
                // A held start from the previous game must not relaunch; wait for low-then-high.
                if (!start) armed_d = 1'b1;
                if (armed_q && start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            last_hit_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            armed_q     <= 1'b0;
            attack_q    <= 1'b0;
            cursor_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            last_hit_q  <= last_hit_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            armed_q     <= armed_d;
            attack_q    <= attack;
            if (valid_shot) cursor_q <= cursor;
        end
    end

    assign active_player = active_q;
    assign last_hit      = last_hit_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;
    assign state         = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - scoreboard bench for turn_scheduler against a game-rules model
module tb_turn_scheduler;

    localparam int TIMEOUT = 10;
    localparam int PAUSE   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, attack = 1'b0;
    logic [35:0] cursor = '0, ships_p0 = '0, ships_p1 = '0;
    logic        active_player, last_hit, game_over, winner;
    logic [35:0] shots_p0, shots_p1;
    logic [14:0] lives_p0, lives_p1;
    logic [2:0]  state;

    turn_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .attack(attack), .cursor(cursor),
        .ships_p0(ships_p0), .ships_p1(ships_p1), .active_player(active_player),
        .shots_p0(shots_p0), .shots_p1(shots_p1), .lives_p0(lives_p0), .lives_p1(lives_p1),
        .last_hit(last_hit), .game_over(game_over), .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        act;
        logic [35:0] s0, s1;
        logic [14:0] l0, l1;
        logic        lh, go, w;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Game model: phase numbers are the documented state encodings.
    int          m_phase, m_ticks, m_pause, m_player;
    int          m_left[2];
    logic [35:0] m_shots[2];
    logic [35:0] m_pending;
    bit          m_last_hit, m_over, m_win, m_armed, m_prev_atk;

    function automatic logic [14:0] therm(input int n);
        return 15'((32'd1 << n) - 32'd1);
    endfunction

    task automatic model_step(input bit r, input bit st, input bit at, input logic [35:0] cur,
                              input logic [35:0] sh0, input logic [35:0] sh1);
        bit          pulse;
        logic [35:0] opp;
        bit          h;
        pulse = at && !m_prev_atk;
        m_prev_atk = at;
        if (!r) begin
            m_phase = 0; m_ticks = 0; m_pause = 0; m_player = 0;
            m_left[0] = 15; m_left[1] = 15; m_shots[0] = '0; m_shots[1] = '0;
            m_last_hit = 0; m_over = 0; m_win = 0; m_armed = 0; m_prev_atk = 0;
            return;
        end
        case (m_phase)
            0: if (st) begin
                m_phase = 1; m_ticks = 0; m_player = 0;
                m_left[0] = 15; m_left[1] = 15; m_shots[0] = '0; m_shots[1] = '0;
                m_last_hit = 0; m_over = 0; m_win = 0;
            end
            1: begin
                if (pulse && $countones(cur) == 1 && (cur & m_shots[m_player]) == '0) begin
                    m_shots[m_player] |= cur;
                    m_pending = cur;
                    m_phase = 2;
                end else if (m_ticks == TIMEOUT - 1) begin
                    m_phase = 3; m_pause = 0;
                end else begin
                    m_ticks++;
                end
            end
            2: begin
                opp = (m_player == 1) ? sh0 : sh1;
                h = (m_pending & opp) != '0;
                m_last_hit = h;
                if (!h) m_left[m_player]--;
                if (opp != '0 && (m_shots[m_player] & opp) == opp) begin
                    m_phase = 4; m_over = 1; m_win = (m_player == 1); m_armed = 0;
                end else if (m_left[m_player] == 0) begin
                    m_phase = 4; m_over = 1; m_win = (m_player == 0); m_armed = 0;
                end else if (h) begin
                    m_phase = 1; m_ticks = 0;
                end else begin
                    m_phase = 3; m_pause = 0;
                end
            end
            3: begin
                if (m_pause == PAUSE - 1) begin
                    m_player = 1 - m_player; m_phase = 1; m_ticks = 0;
                end else begin
                    m_pause++;
                end
            end
            default: begin
                if (m_armed && st) m_phase = 0;
                if (!st) m_armed = 1;
            end
        endcase
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.st = 3'(m_phase); s.act = (m_player == 1);
        s.s0 = m_shots[0]; s.s1 = m_shots[1];
        s.l0 = therm(m_left[0]); s.l1 = therm(m_left[1]);
        s.lh = m_last_hit; s.go = m_over; s.w = m_win;
        return s;
    endfunction

    task automatic cyc(input bit r, input bit st, input bit at, input logic [35:0] cur);
        snap_t e;
        reset = r; start = st; attack = at; cursor = cur;
        model_step(r, st, at, cur, ships_p0, ships_p1);
        e = model_snap();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic fire(input logic [35:0] cur);
        cyc(1, 0, 1, cur);
        cyc(1, 0, 0, cur);
    endtask

    task automatic wait_turn(input int p);
        for (int i = 0; i < 60; i++) begin
            if (m_phase == 1 && m_player == p) return;
            cyc(1, 0, 0, '0);
        end
        total++; bad++;
        $display("FAIL wait_turn: player %0d never got a turn (model phase %0d)", p, m_phase);
    endtask

    initial begin : monitor
        snap_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: state, act: active_player, s0: shots_p0, s1: shots_p1,
                      l0: lives_p0, l1: lives_p1, lh: last_hit, go: game_over, w: winner};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got st=%0d act=%0d s0=%h s1=%h l0=%h l1=%h lh=%0d go=%0d w=%0d want st=%0d act=%0d s0=%h s1=%h l0=%h l1=%h lh=%0d go=%0d w=%0d",
                             $time, a.st, a.act, a.s0, a.s1, a.l0, a.l1, a.lh, a.go, a.w,
                             e.st, e.act, e.s0, e.s1, e.l0, e.l1, e.lh, e.go, e.w);
                end
            end
        end
    end

    initial begin : driver
        logic [35:0] c;
        ships_p0 = 36'h30;
        ships_p1 = 36'hF;
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 0, 0, '0);
        fire(36'h1);
        fire(36'h1 << 20);
        wait_turn(1);
        fire(36'h10);
        fire(36'h10);
        fire(36'h3);
        wait_turn(0);
        fire(36'h2);
        fire(36'h4);
        fire(36'h8);
        fire(36'h100);
        cyc(1, 0, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 15; i++) begin
            wait_turn(1);
            fire(36'h40 << i);
        end
        cyc(1, 0, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 0, 0, '0);
        fire(36'h1 << 30);
        cyc(0, 0, 0, '0);
        cyc(1, 0, 0, '0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                c = {$urandom, $urandom} & {$urandom, $urandom};
                ships_p0 = ($urandom_range(0, 7) == 0) ? 36'h0 : c;
                c = {$urandom, $urandom} & {$urandom, $urandom};
                ships_p1 = ($urandom_range(0, 7) == 0) ? 36'h0 : c;
                cyc(0, 0, 0, '0);
            end else begin
                case ($urandom_range(0, 9))
                    0:       c = {$urandom, $urandom};
                    1:       c = '0;
                    default: begin c = 36'h1; c = c << $urandom_range(0, 35); end
                endcase
                cyc(1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, c);
            end
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d expected snapshots never checked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Two-player turn controller for the 6x6 battleship board.
- Shares the single cursor/attack datapath (one grid_controller cursor, one debounced attack line) between player 0 and player 1.
- Owns each player's shot grid, miss budget ("lives") and win/loss detection; sequences turns with a hand-over pause.
- Sits between the debouncers/grid_controller and vga_display/seven_seg, and replaces single-player grid_attack sequencing.

Parameters:
- GRID_CELLS, 36, number of board cells (one-hot cursor width).
- MAX_MISSES, 15, misses allowed per player before that player loses.
- SWITCH_CYCLES, 2, pause cycles in SWITCH before the other player's turn starts.
- TURN_TIMEOUT, 10, cycles without a valid attack before the turn is forfeited.

Ports:
- clk  in  1  system clock (game tick domain).
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; begins a game from IDLE.
- attack  in  1  debounced attack button, level; rising edge detected internally.
- cursor  in  36  one-hot selected cell.
- ships_p0  in  36  player 0 fleet map, stable during a game.
- ships_p1  in  36  player 1 fleet map, stable during a game.
- active_player  out  1  0/1; whose turn it is.
- shots_p0  out  36  cells player 0 has fired on (player 1's board).
- shots_p1  out  36  cells player 1 has fired on (player 0's board).
- lives_p0  out  15  thermometer of player 0's remaining misses.
- lives_p1  out  15  thermometer of player 1's remaining misses.
- last_hit  out  1  1 if the most recent resolved shot was a hit.
- game_over  out  1  game finished.
- winner  out  1  valid when game_over.
- state  out  3  FSM state encoding, for debug and display.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; all outputs 0 except lives_p0=lives_p1=15'h7FFF; edge-detect register cleared.
- Attack edge: atk_pulse = attack & ~attack_q. attack_q is registered every cycle, including in IDLE.
- Valid shot: atk_pulse and cursor is exactly one-hot and (cursor & own_shots)==0.
  - Any other atk_pulse is ignored. The turn stays, and the timeout counter is not reset.
- FSM states, with encodings:
  - IDLE (0):
    - start==1 -> TURN next cycle, active_player=0.
    - On entry into TURN from IDLE, clear shots, lives, last_hit, game_over and winner.
  - TURN (1):
    - Timeout counter increments each cycle.
    - Valid shot -> RESOLVE; own_shots |= cursor, registered in the same edge.
    - Counter reaching TURN_TIMEOUT-1 with no valid shot -> SWITCH (forfeit, no life lost).
    - A valid shot on the timeout cycle wins: goes to RESOLVE.
  - RESOLVE (2), one cycle:
    - hit = |(cursor_q & opp_ships); last_hit <= hit.
    - Miss: own lives <= lives >> 1.
    - If (own_shots & opp_ships)==opp_ships (opp_ships nonzero) -> OVER, winner=active_player.
    - Else if own lives becomes 0 -> OVER, winner=~active_player.
    - Else hit -> TURN, same player (extra shot), counter cleared.
    - Else miss -> SWITCH.
  - SWITCH (3): waits SWITCH_CYCLES cycles, then toggles active_player -> TURN, counter cleared.
  - OVER (4):
    - game_over=1; all grids frozen; attacks ignored.
    - start must be seen low, then high, before going to IDLE -> TURN with a fresh game.
- Latency: shot grid is updated 1 cycle after the attack edge. Lives, last_hit and game_over are updated 2 cycles after it.
- Both-sides win in the same cycle is impossible: only one player resolves per cycle.
- Empty fleet (opp_ships==0) never triggers a win.
- Reset mid-game: returns to IDLE on the same edge; no partial state survives.

Decomposition:
- Shared package: GRID_CELLS, MAX_MISSES, state encodings (ST_IDLE..ST_OVER), and a onehot36 check function.
- One sub-module, player_board: shot register, lives thermometer and fleet-sunk compare. It is instantiated twice and selected by active_player.

Test Plan:
- Reset, then start=1 → state=1, active_player=0, lives_p0=lives_p1=15'h7FFF, shots all 0.
- P0 attacks cursor=36'h1 with ships_p1 bit0=1 → shots_p0=36'h1 next cycle; last_hit=1 the cycle after; active_player stays 0.
- P0 attacks a miss cell → lives_p0=15'h3FFF; 2 SWITCH cycles; then active_player=1.
- P1 re-attacks an already-shot cell, then cursor=36'h3 (not one-hot) → both ignored; after 10 idle cycles the turn forfeits to P0 with lives unchanged.
- P0 sinks all of ships_p1=36'h00000000F → game_over=1, winner=0, state=4; further attacks leave shots unchanged.
- P1 misses 15 times → lives_p1=0, game_over=1, winner=0. Assert reset=0 mid-game → next cycle state=0 and lives restored to 15'h7FFF.
